systolic_tile_ctrl: RTL and testbench

//  Sequencer for a ROWS x COLS weight-stationary systolic array. Per tile it

---
 rtl/systolic_tile_ctrl_pkg.sv | 33 +++
 rtl/systolic_tile_ctrl_if.sv | 43 ++++
 rtl/systolic_tile_ctrl_tile_window.sv | 25 ++
 rtl/systolic_tile_ctrl.sv | 174 +++++++++++++++++
 tb/tb_systolic_tile_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_tile_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_tile_ctrl_pkg
// Description : Shared types for the systolic tile sequencer: the per-PE
//               input mux select, the controller state encoding and a small
//               helper that says when a new tile may be accepted.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_tile_ctrl_pkg;

  // Per-PE input mux select driven into the grid.
  typedef enum logic [1:0] {
    MUX_IDLE    = 2'd0,
    PASSTHROUGH = 2'd1,
    LOAD        = 2'd2,
    PROCESS     = 2'd3
  } input_mux_t;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PROC = 2'd2,
    S_DONE = 2'd3
  } ctrl_state_t;

  // A tile request is only considered while the grid is not in use.
  function automatic logic can_accept(ctrl_state_t s);
    return (s == S_IDLE) || (s == S_DONE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_tile_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : systolic_tile_ctrl_if
// Description : Command / PE-grid bundle of the systolic tile sequencer.
//               Command side : start_i, len_i, reuse_i, abort_i
//               Status       : busy_o, done_o
//               Grid side    : in_valid_o (per row), mux_o (per PE),
//                              add_zero_o (per PE), acc_valid_o (per column)
//               master = command path / driver, slave = sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface systolic_tile_ctrl_if
  import systolic_tile_ctrl_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int LEN_W = 8
);

  logic                       start_i;
  logic [LEN_W-1:0]           len_i;
  logic                       reuse_i;
  logic                       abort_i;

  logic                       busy_o;
  logic                       done_o;
  logic [ROWS-1:0]            in_valid_o;
  input_mux_t                 mux_o [ROWS][COLS];
  logic [ROWS-1:0][COLS-1:0]  add_zero_o;
  logic [COLS-1:0]            acc_valid_o;

  modport master (
    output start_i, len_i, reuse_i, abort_i,
    input  busy_o, done_o, in_valid_o, mux_o, add_zero_o, acc_valid_o
  );

  modport slave (
    input  start_i, len_i, reuse_i, abort_i,
    output busy_o, done_o, in_valid_o, mux_o, add_zero_o, acc_valid_o
  );

endinterface
`default_nettype wire

// File: rtl/systolic_tile_ctrl_tile_window.sv
`default_nettype none
// ============================================================================
// Module      : systolic_tile_ctrl_tile_window
// Description : Half-open window detector: hit_o = lo_i <= cnt_i < lo_i+len_i.
//               Ports: cnt_i (current cycle), lo_i (window start),
//               len_i (window length), hit_o (inside window).
//               CNT_W must be wide enough that lo_i+len_i never wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_tile_ctrl_tile_window #(
  parameter int CNT_W = 9
) (
  input  wire [CNT_W-1:0] cnt_i,
  input  wire [CNT_W-1:0] lo_i,
  input  wire [CNT_W-1:0] len_i,
  output logic            hit_o
);

  logic [CNT_W-1:0] w_hi;

  assign w_hi  = lo_i + len_i;
  assign hit_o = (cnt_i >= lo_i) && (cnt_i < w_hi);

endmodule
`default_nettype wire

// File: rtl/systolic_tile_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : systolic_tile_ctrl
// Description : Sequencer for a ROWS x COLS weight-stationary systolic array.
//               Per tile: shift in stationary weights (S_LOAD, skippable on
//               reuse), stream len skewed input vectors while flagging the
//               column accumulators (S_PROC), then pulse done (S_DONE).
//               Ports: clk_i, rst_i (async, active high) and the slave side
//               of systolic_tile_ctrl_if (command, status and grid controls).
//               All grid/status outputs are decoded from state and counter.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_tile_ctrl
  import systolic_tile_ctrl_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int LEN_W = 8
) (
  input  wire                 clk_i,
  input  wire                 rst_i,
  systolic_tile_ctrl_if.slave bus
);

  // Sized so the longest process phase (len + ROWS + COLS - 1) and every
  // window upper bound fit without wrapping.
  localparam int CNT_W = $clog2(2**LEN_W + ROWS + COLS);

  ctrl_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [LEN_W-1:0]  len_q,   len_d;
  logic              wts_ok_q, wts_ok_d;

  logic              w_accept;
  logic [CNT_W-1:0]  w_len_ext;
  logic [CNT_W-1:0]  w_proc_last;
  logic [ROWS-1:0]   w_row_hit;
  logic [COLS-1:0]   w_col_hit;
  input_mux_t        w_mux;

  assign w_len_ext   = CNT_W'(len_q);
  // Last process cycle index: P-1 = len + ROWS + COLS - 2.
  assign w_proc_last = w_len_ext + CNT_W'(ROWS + COLS - 2);

  // Abort takes priority over a simultaneous start; zero-length tiles are dropped.
  assign w_accept = bus.start_i && !bus.abort_i && (bus.len_i != '0) && can_accept(state_q);

  // --------------------------------------------------------------------------
  // Skew windows: row r is fed on cycles [r, r+len-1]; column c's result
  // leaves the bottom row on cycles [ROWS+c, ROWS+c+len-1].
  // --------------------------------------------------------------------------
  generate
    for (genvar r = 0; r < ROWS; r++) begin : g_row_win
      systolic_tile_ctrl_tile_window #(.CNT_W(CNT_W)) u_win (
        .cnt_i (cnt_q),
        .lo_i  (CNT_W'(r)),
        .len_i (w_len_ext),
        .hit_o (w_row_hit[r])
      );
    end
    for (genvar c = 0; c < COLS; c++) begin : g_col_win
      systolic_tile_ctrl_tile_window #(.CNT_W(CNT_W)) u_win (
        .cnt_i (cnt_q),
        .lo_i  (CNT_W'(ROWS + c)),
        .len_i (w_len_ext),
        .hit_o (w_col_hit[c])
      );
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state logic. The counter restarts at zero on every state entry.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    len_d    = len_q;
    wts_ok_d = wts_ok_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (w_accept) begin
          len_d   = bus.len_i;
          state_d = (bus.reuse_i && wts_ok_q) ? S_PROC : S_LOAD;
        end
      end
      S_LOAD: begin
        if (cnt_q == CNT_W'(ROWS - 1)) begin
          state_d  = S_PROC;
          cnt_d    = '0;
          wts_ok_d = 1'b1;
        end
      end
      S_PROC: begin
        if (cnt_q == w_proc_last) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
        // Back-to-back tile: go straight on with no idle gap.
        if (w_accept) begin
          len_d   = bus.len_i;
          state_d = (bus.reuse_i && wts_ok_q) ? S_PROC : S_LOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort drops the tile and invalidates whatever weights are in the grid.
    if (bus.abort_i) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      wts_ok_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      wts_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      wts_ok_q <= wts_ok_d;
    end
  end

  // --------------------------------------------------------------------------
  // Moore output decode.
  // --------------------------------------------------------------------------
  always_comb begin
    w_mux            = MUX_IDLE;
    bus.busy_o       = (state_q == S_LOAD) || (state_q == S_PROC);
    bus.done_o       = (state_q == S_DONE);
    bus.in_valid_o   = '0;
    bus.acc_valid_o  = '0;
    bus.add_zero_o   = '0;

    case (state_q)
      S_LOAD: begin
        // Weights ripple down for ROWS-1 cycles, then every PE captures.
        w_mux = (cnt_q == CNT_W'(ROWS - 1)) ? LOAD : PASSTHROUGH;
      end
      S_PROC: begin
        w_mux             = PROCESS;
        // Top row has no north neighbour, so it starts its partial sum at 0.
        bus.add_zero_o[0] = '1;
        bus.in_valid_o    = w_row_hit;
        bus.acc_valid_o   = w_col_hit;
      end
      default: begin
        w_mux = MUX_IDLE;
      end
    endcase

    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        bus.mux_o[r][c] = w_mux;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_tile_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_tile_ctrl
// Description : Scoreboard bench for systolic_tile_ctrl (ROWS=COLS=4,
//               LEN_W=8). Stimulus pushes the expected per-cycle output
//               snapshot of each tile; a negedge monitor pops and compares
//               whenever the sequencer is busy or done, and checks idle
//               outputs otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_tile_ctrl;
  import systolic_tile_ctrl_pkg::*;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int LEN_W = 8;
  localparam int BIG   = 100000;

  // Snapshot: {busy, done, mux[1:0], mux_uniform, in_valid[3:0], acc_valid[3:0], add_zero[15:0]}
  localparam logic [28:0] IDLE_SNAP = {1'b0, 1'b0, 2'b00, 1'b1, 4'b0, 4'b0, 16'b0};

  typedef struct {
    int          test;
    int          idx;
    logic [28:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_tile_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .LEN_W(LEN_W)) bus();

  systolic_tile_ctrl #(.ROWS(ROWS), .COLS(COLS), .LEN_W(LEN_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  function automatic logic [28:0] mk(logic busy, logic done, logic [1:0] mux,
                                     logic [3:0] iv, logic [3:0] av, logic [15:0] az);
    return {busy, done, mux, 1'b1, iv, av, az};
  endfunction

  function automatic logic all_mux_is(input_mux_t m);
    logic ok;
    ok = 1'b1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (bus.mux_o[r][c] !== m) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [28:0] sample_dut();
    logic uni;
    uni = all_mux_is(bus.mux_o[0][0]);
    return {bus.busy_o, bus.done_o, bus.mux_o[0][0], uni,
            bus.in_valid_o, bus.acc_valid_o, bus.add_zero_o};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Expected snapshots of one tile, truncated to 'limit' cycles.
  task automatic push_tile(int test, int len, bit load, int limit);
    int         n;
    int         p;
    exp_t       e;
    logic [3:0] iv;
    logic [3:0] av;
    n = 0;
    p = len + ROWS + COLS - 1;
    e.test = test;
    if (load) begin
      for (int i = 0; i < ROWS; i++) begin
        if (n < limit) begin
          e.idx = n;
          e.exp = mk(1'b1, 1'b0, (i == ROWS-1) ? LOAD : PASSTHROUGH, 4'b0, 4'b0, 16'b0);
          sb_q.push_back(e);
          n++;
        end
      end
    end
    for (int t = 0; t < p; t++) begin
      if (n < limit) begin
        for (int r = 0; r < ROWS; r++) iv[r] = (t >= r) && (t < r + len);
        for (int c = 0; c < COLS; c++) av[c] = (t >= ROWS + c) && (t < ROWS + c + len);
        e.idx = n;
        e.exp = mk(1'b1, 1'b0, PROCESS, iv, av, 16'h000F);
        sb_q.push_back(e);
        n++;
      end
    end
    if (n < limit) begin
      e.idx = n;
      e.exp = mk(1'b0, 1'b1, MUX_IDLE, 4'b0, 4'b0, 16'b0);
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_pulse(int len, bit reuse);
    bus.start_i = 1'b1;
    bus.len_i   = LEN_W'(len);
    bus.reuse_i = reuse;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.reuse_i = 1'b0;
  endtask

  // Monitor: compares DUT outputs every cycle away from the active edge.
  logic [28:0] mon_act;
  exp_t        mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      mon_act = sample_dut();
      checks++;
      if (bus.busy_o || bus.done_o) begin
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_activity act=%h exp=none", mon_act);
        end else begin
          mon_e = sb_q.pop_front();
          if (mon_act !== mon_e.exp) begin
            errors++;
            $display("FAIL tile%0d_cyc%0d act=%h exp=%h", mon_e.test, mon_e.idx, mon_act, mon_e.exp);
          end
        end
      end else if (mon_act !== IDLE_SNAP) begin
        errors++;
        $display("FAIL idle_outputs act=%h exp=%h", mon_act, IDLE_SNAP);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i = 1'b0;
    bus.len_i   = '0;
    bus.reuse_i = 1'b0;
    bus.abort_i = 1'b0;
    #1;
    check("reset_mux_idle", 32'(all_mux_is(MUX_IDLE)), 1);
    check("reset_busy",     32'(bus.busy_o), 0);
    check("reset_done",     32'(bus.done_o), 0);
    check("reset_outputs",  {bus.in_valid_o, bus.acc_valid_o, bus.add_zero_o}, 0);
    #11;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: full tile with LOAD, len=3.
    push_tile(1, 3, 1'b1, BIG);
    start_pulse(3, 1'b0);
    wait_cycles(6);                                   // PROC t=2
    check("t1_in_valid_t2", 32'(bus.in_valid_o), 32'h7);
    wait_cycles(5);                                   // PROC t=7
    check("t1_acc_valid_t7", 32'(bus.acc_valid_o), 32'hE);
    wait_cycles(3);                                   // S_DONE, 15th cycle
    check("t1_done_pulse", 32'(bus.done_o), 1);
    check("t1_busy_in_done", 32'(bus.busy_o), 0);

    // 2: reuse start held through S_DONE -> straight into PROC.
    push_tile(2, 2, 1'b0, BIG);
    start_pulse(2, 1'b1);
    wait_cycles(4);                                   // PROC t=4
    check("t2_acc_valid_t4", 32'(bus.acc_valid_o), 32'h1);
    wait_cycles(6);

    // 3: abort on LOAD cycle 2, then reuse start must reload.
    push_tile(3, 5, 1'b1, 3);
    start_pulse(5, 1'b0);
    wait_cycles(2);
    bus.abort_i = 1'b1;
    wait_cycles(1);
    bus.abort_i = 1'b0;
    check("t3_abort_idle", 32'(bus.busy_o), 0);
    check("t3_abort_no_done", 32'(bus.done_o), 0);
    push_tile(4, 1, 1'b1, BIG);
    start_pulse(1, 1'b1);
    wait_cycles(13);

    // Abort and start together: start dropped, weights invalidated.
    bus.start_i = 1'b1;
    bus.len_i   = 8'd2;
    bus.reuse_i = 1'b1;
    bus.abort_i = 1'b1;
    wait_cycles(1);
    bus.start_i = 1'b0;
    bus.reuse_i = 1'b0;
    bus.abort_i = 1'b0;
    check("abort_beats_start", 32'(bus.busy_o), 0);
    push_tile(5, 2, 1'b1, BIG);
    start_pulse(2, 1'b1);
    wait_cycles(14);

    // 4: zero-length start ignored; start and len changes mid-run ignored.
    bus.start_i = 1'b1;
    bus.len_i   = 8'd0;
    wait_cycles(1);
    bus.start_i = 1'b0;
    check("t4_len0_ignored", 32'(bus.busy_o), 0);
    push_tile(6, 4, 1'b1, BIG);
    start_pulse(4, 1'b0);
    wait_cycles(6);
    bus.start_i = 1'b1;
    bus.len_i   = 8'd9;
    bus.reuse_i = 1'b1;
    wait_cycles(2);
    bus.start_i = 1'b0;
    bus.len_i   = 8'd200;
    bus.reuse_i = 1'b0;
    wait_cycles(8);

    // 5: maximum length with reuse.
    push_tile(7, 255, 1'b0, BIG);
    start_pulse(255, 1'b1);
    wait_cycles(258);                                 // PROC t=258
    check("t5_acc_valid_t258", 32'(bus.acc_valid_o), 32'hF);
    wait_cycles(1);                                   // PROC t=259
    check("t5_acc_valid_t259", 32'(bus.acc_valid_o), 32'hE);
    wait_cycles(3);                                   // S_DONE
    check("t5_done_pulse", 32'(bus.done_o), 1);
    wait_cycles(1);
    check("t5_done_once", 32'(bus.done_o), 0);

    // 6: async reset mid-PROC, then reuse start must reload.
    push_tile(8, 6, 1'b1, 9);
    start_pulse(6, 1'b0);
    wait_cycles(8);                                   // PROC t=4
    #5;
    rst = 1'b1;
    #1;
    check("t6_rst_mux_idle", 32'(all_mux_is(MUX_IDLE)), 1);
    check("t6_rst_acc_valid", 32'(bus.acc_valid_o), 0);
    check("t6_rst_busy", 32'(bus.busy_o), 0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    push_tile(9, 2, 1'b1, BIG);
    start_pulse(2, 1'b1);
    wait_cycles(14);

    wait_cycles(2);
    check("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
